fsub_arb: RTL and testbench

FSUB_ARB -- requirements
Module: fsub_arb

---
 rtl/fpu_arb_pkg.sv | 44 ++++
 rtl/fsub.sv | 145 ++++++++++++++
 rtl/fsub_arb.sv | 120 ++++++++++++
 tb/tb_fsub_arb.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_arb_pkg
//  Description : Shared definitions for the two-requester floating-point
//                subtract arbiter: requester count, default unit latency,
//                op encodings, the in-flight tag type and a leading-zero
//                counter used by the subtract unit's normaliser.
//  Revision    : 1.0  initial release
// ============================================================================
package fpu_arb_pkg;

    // Number of requesters sharing the subtract unit
    localparam int NREQ        = 2;

    // Default fixed latency of the shared subtract unit, in clocks
    localparam int LAT_DEFAULT = 2;

    // Per-requester operation select
    typedef enum logic {
        OP_SUB = 1'b0,   // y = x1 - x2
        OP_ADD = 1'b1    // y = x1 + x2
    } op_e;

    // One entry of the tag pipeline that travels alongside the unit
    typedef struct packed {
        logic v;    // an accepted operation occupies this slot
        logic id;   // requester that owns the operation
    } tag_t;

    // Leading-zero count of a 27-bit vector (27 when the vector is zero).
    // Ascending scan: the highest set bit is the last one to overwrite.
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) begin
                n = 5'(26 - i);
            end
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fsub.sv
`default_nettype none
// ============================================================================
//  Module      : fsub
//  Description : IEEE-754 single-precision subtract unit, y = x1 - x2,
//                round-to-nearest-even, non-stallable, one issue per clock.
//                Operands are sampled at edge N; y is valid after edge
//                N+LAT-1. Datapath registers are intentionally unreset.
//  Ports       : clk  in   clock, rising edge
//                x1   in   32  minuend
//                x2   in   32  subtrahend
//                y    out  32  difference
//  Revision    : 1.0  initial release
// ============================================================================
module fsub
    import fpu_arb_pkg::*;
#(
    parameter int LAT = LAT_DEFAULT
) (
    input  logic        clk,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic [31:0] y
);

    logic [31:0] r_x1, r_x2;

    always_ff @(posedge clk) begin
        r_x1 <= x1;
        r_x2 <= x2;
    end

    logic        w_sa, w_sb, w_sl, w_ss, w_swap;
    logic [7:0]  w_ea, w_eb, w_el8, w_es8;
    logic [22:0] w_ma, w_mb, w_ml23, w_ms23;
    logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf;
    logic [9:0]  w_el, w_es, w_d, w_sh, w_exp;
    logic [23:0] w_ml, w_ms;
    logic [26:0] w_al, w_as, w_shifted, w_lost_mask, w_small, w_norm;
    logic        w_sticky, w_rup;
    logic [27:0] w_sum;
    logic [4:0]  w_lz;
    logic [7:0]  w_ef;
    logic [30:0] w_mag;
    logic [31:0] w_res;

    always_comb begin
        w_sa        = r_x1[31];
        w_ea        = r_x1[30:23];
        w_ma        = r_x1[22:0];
        // x1 - x2 is computed as x1 + (-x2)
        w_sb        = ~r_x2[31];
        w_eb        = r_x2[30:23];
        w_mb        = r_x2[22:0];

        w_a_nan     = (w_ea == 8'hFF) && (w_ma != 23'd0);
        w_b_nan     = (w_eb == 8'hFF) && (w_mb != 23'd0);
        w_a_inf     = (w_ea == 8'hFF) && (w_ma == 23'd0);
        w_b_inf     = (w_eb == 8'hFF) && (w_mb == 23'd0);

        // Order operands by magnitude so the large one sets sign and exponent
        w_swap      = {w_eb, w_mb} > {w_ea, w_ma};
        w_sl        = w_swap ? w_sb : w_sa;
        w_ss        = w_swap ? w_sa : w_sb;
        w_el8       = w_swap ? w_eb : w_ea;
        w_es8       = w_swap ? w_ea : w_eb;
        w_ml23      = w_swap ? w_mb : w_ma;
        w_ms23      = w_swap ? w_ma : w_mb;

        // Subnormals use exponent 1 with no hidden bit
        w_el        = (w_el8 == 8'd0) ? 10'd1 : {2'b00, w_el8};
        w_es        = (w_es8 == 8'd0) ? 10'd1 : {2'b00, w_es8};
        w_ml        = {w_el8 != 8'd0, w_ml23};
        w_ms        = {w_es8 != 8'd0, w_ms23};
        w_d         = w_el - w_es;

        // Three extra bits below the mantissa: guard, round, sticky
        w_al        = {w_ml, 3'b000};
        w_as        = {w_ms, 3'b000};
        w_lost_mask = '0;
        if (w_d > 10'd26) begin
            w_shifted = '0;
            w_sticky  = |w_ms;
        end else begin
            w_shifted   = w_as >> w_d;
            w_lost_mask = (27'd1 << w_d) - 27'd1;
            w_sticky    = |(w_as & w_lost_mask);
        end
        w_small     = w_shifted | {26'd0, w_sticky};

        w_sum       = (w_sl ^ w_ss) ? ({1'b0, w_al} - {1'b0, w_small})
                                    : ({1'b0, w_al} + {1'b0, w_small});

        // Normalise: one-bit right shift on carry-out, otherwise left shift
        // by the leading-zero count, limited so the exponent stays >= 1.
        w_lz        = lzc27(w_sum[26:0]);
        w_sh        = '0;
        if (w_sum[27]) begin
            w_norm = {w_sum[27:2], w_sum[1] | w_sum[0]};
            w_exp  = w_el + 10'd1;
        end else begin
            w_sh   = ({5'd0, w_lz} < (w_el - 10'd1)) ? {5'd0, w_lz} : (w_el - 10'd1);
            w_norm = w_sum[26:0] << w_sh;
            w_exp  = w_el - w_sh;
        end
        w_ef        = w_norm[26] ? w_exp[7:0] : 8'd0;

        // Round to nearest even; the carry ripples into the exponent field,
        // covering subnormal->normal and largest-normal->infinity.
        w_rup       = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_mag       = {w_ef, w_norm[25:3]} + {30'd0, w_rup};

        if (w_a_nan || w_b_nan) begin
            w_res = 32'h7FC0_0000;
        end else if (w_a_inf && w_b_inf) begin
            w_res = (w_sa != w_sb) ? 32'h7FC0_0000 : {w_sa, 8'hFF, 23'd0};
        end else if (w_a_inf) begin
            w_res = {w_sa, 8'hFF, 23'd0};
        end else if (w_b_inf) begin
            w_res = {w_sb, 8'hFF, 23'd0};
        end else if (w_sum == 28'd0) begin
            w_res = 32'h0000_0000;
        end else if (w_exp >= 10'd255) begin
            w_res = {w_sl, 8'hFF, 23'd0};
        end else begin
            w_res = {w_sl, w_mag};
        end
    end

    generate
        if (LAT == 1) begin : g_direct
            assign y = w_res;
        end else begin : g_pipe
            logic [31:0] r_pipe [LAT-1];
            always_ff @(posedge clk) begin
                r_pipe[0] <= w_res;
                for (int i = 1; i < LAT - 1; i++) begin
                    r_pipe[i] <= r_pipe[i-1];
                end
            end
            assign y = r_pipe[LAT-2];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/fsub_arb.sv
`default_nettype none
// ============================================================================
//  Module      : fsub_arb
//  Description : Round-robin arbiter sharing one fsub unit between two
//                requesters. Op 0 gives x1-x2, op 1 gives x1+x2 (x2 sign
//                flipped on the way in). A tag pipeline follows each
//                operation through the unit and steers its result to the
//                owning requester as a one-cycle pulse.
//  Ports       : clk        in   clock, rising edge
//                rstn       in   synchronous active-low reset
//                req_valid  in   2   per-requester request
//                req_ready  out  2   per-requester accept
//                req_op     in   2   per-requester op select
//                req_x1_0/req_x2_0/req_x1_1/req_x2_1  in  32  operands
//                res_valid  out  2   per-requester result pulse
//                res_y_0/res_y_1     out 32  results (held between pulses)
//                busy       out  1   any operation in flight
//  Revision    : 1.0  initial release
// ============================================================================
module fsub_arb
    import fpu_arb_pkg::*;
#(
    parameter int LAT = LAT_DEFAULT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [NREQ-1:0]  req_valid,
    output logic [NREQ-1:0]  req_ready,
    input  logic [NREQ-1:0]  req_op,
    input  logic [31:0]      req_x1_0,
    input  logic [31:0]      req_x2_0,
    input  logic [31:0]      req_x1_1,
    input  logic [31:0]      req_x2_1,
    output logic [NREQ-1:0]  res_valid,
    output logic [31:0]      res_y_0,
    output logic [31:0]      res_y_1,
    output logic             busy
);

    logic               r_ptr;
    logic [NREQ-1:0]    w_ready;
    logic [NREQ-1:0]    w_take;
    logic               w_gnt;
    logic               w_gid;
    logic               w_add;
    logic [31:0]        w_a, w_b, w_y;
    tag_t [LAT-1:0]     r_tag;
    logic [LAT-1:0]     w_tag_v;
    logic [NREQ-1:0]    r_res_valid;
    logic [31:0]        r_res_y0, r_res_y1;
    logic               w_out_v0, w_out_v1;

    // A requester is ready when it holds the pointer or the other side is
    // idle, so at most one is ready whenever both are requesting.
    always_comb begin
        w_ready[0] = rstn & (~r_ptr | ~req_valid[1]);
        w_ready[1] = rstn & ( r_ptr | ~req_valid[0]);
    end

    assign w_take = req_valid & w_ready;
    assign w_gnt  = |w_take;
    assign w_gid  = w_take[1];
    assign w_add  = (req_op[w_gid] == OP_ADD);
    assign w_a    = w_gid ? req_x1_1 : req_x1_0;
    assign w_b    = (w_gid ? req_x2_1 : req_x2_0) ^ {w_add, 31'd0};

    fsub #(
        .LAT (LAT)
    ) u_fsub (
        .clk (clk),
        .x1  (w_a),
        .x2  (w_b),
        .y   (w_y)
    );

    // The last tag slot lines up with the unit output
    assign w_out_v0 = r_tag[LAT-1].v & ~r_tag[LAT-1].id;
    assign w_out_v1 = r_tag[LAT-1].v &  r_tag[LAT-1].id;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_ptr       <= 1'b0;
            r_tag       <= '0;
            r_res_valid <= '0;
            r_res_y0    <= '0;
            r_res_y1    <= '0;
        end else begin
            if (w_gnt) begin
                r_ptr <= ~w_gid;
            end
            r_tag[0].v  <= w_gnt;
            r_tag[0].id <= w_gid;
            for (int i = 1; i < LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
            r_res_valid <= {w_out_v1, w_out_v0};
            if (w_out_v0) begin
                r_res_y0 <= w_y;
            end
            if (w_out_v1) begin
                r_res_y1 <= w_y;
            end
        end
    end

    always_comb begin
        w_tag_v = '0;
        for (int i = 0; i < LAT; i++) begin
            w_tag_v[i] = r_tag[i].v;
        end
    end

    assign req_ready = w_ready;
    assign res_valid = r_res_valid;
    assign res_y_0   = r_res_y0;
    assign res_y_1   = r_res_y1;
    assign busy      = (|w_tag_v) | (|r_res_valid);

endmodule
`default_nettype wire

// File: tb/tb_fsub_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fsub_arb
//  Description : Self-checking bench for fsub_arb. Operands are multiples of
//                1/8 so every sum/difference is exact in single precision;
//                expected results come from integer arithmetic converted to
//                float bits. A queue of expected results (due cycle, owner,
//                value) models arbitration, latency, holding and busy.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fsub_arb;

    localparam int LAT = 2;

    logic        clk;
    logic        rstn;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_x1_0, req_x2_0, req_x1_1, req_x2_1;
    logic [1:0]  res_valid;
    logic [31:0] res_y_0, res_y_1;
    logic        busy;

    fsub_arb #(
        .LAT (LAT)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_x1_0  (req_x1_0),
        .req_x2_0  (req_x2_0),
        .req_x1_1  (req_x1_1),
        .req_x2_1  (req_x2_1),
        .res_valid (res_valid),
        .res_y_0   (res_y_0),
        .res_y_1   (res_y_1),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic        id;
        logic [31:0] y;
    } ent_t;

    ent_t        q[$];
    int          cyc     = 0;
    int          n_check = 0;
    int          n_fail  = 0;
    logic        m_ptr   = 1'b0;
    logic [31:0] m_last [2];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_check++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Value e8/8 as single-precision bits (exact for |e8| < 2^24)
    function automatic logic [31:0] f2b(input int e8);
        real         r;
        logic [63:0] d;
        int          e;
        if (e8 == 0) return 32'h0000_0000;
        r = real'(e8) / 8.0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic int rv();
        return int'($urandom_range(65535)) - 32768;
    endfunction

    // Sign of an exact zero is left to the unit
    task automatic check_y(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        if (exp[30:0] == 31'd0) check_eq(tag, {1'b0, obs[30:0]}, {1'b0, exp[30:0]});
        else                    check_eq(tag, obs, exp);
    endtask

    task automatic check_outputs();
        logic [1:0]  erv;
        logic [31:0] ey [2];
        logic        eb;
        erv   = 2'b00;
        eb    = 1'b0;
        ey[0] = m_last[0];
        ey[1] = m_last[1];
        while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
        foreach (q[i]) begin
            eb = 1'b1;
            if (q[i].due == cyc) begin
                erv[q[i].id] = 1'b1;
                ey[q[i].id]  = q[i].y;
            end
        end
        check_eq("res_valid", {30'd0, res_valid}, {30'd0, erv});
        check_eq("busy", {31'd0, busy}, {31'd0, eb});
        check_y("res_y_0", res_y_0, ey[0]);
        check_y("res_y_1", res_y_1, ey[1]);
        m_last[0] = ey[0];
        m_last[1] = ey[1];
    endtask

    // One clock with reset released; called and returning at a negedge
    task automatic cycle(input logic [1:0] v, input logic [1:0] op,
                         input int a0, input int b0, input int a1, input int b1);
        logic [1:0] mr, take;
        logic       gid;
        ent_t       e;
        req_valid = v;
        req_op    = op;
        req_x1_0  = f2b(a0);
        req_x2_0  = f2b(b0);
        req_x1_1  = f2b(a1);
        req_x2_1  = f2b(b1);
        #1;
        mr[0] = (m_ptr == 1'b0) || !v[0+1];
        mr[1] = (m_ptr == 1'b1) || !v[0];
        check_eq("req_ready", {30'd0, req_ready}, {30'd0, mr});
        take = v & mr;
        if (take != 2'b00) begin
            gid   = take[1];
            e.due = cyc + 1 + LAT;
            e.id  = gid;
            if (gid) e.y = f2b(op[1] ? a1 + b1 : a1 - b1);
            else     e.y = f2b(op[0] ? a0 + b0 : a0 - b0);
            q.push_back(e);
            m_ptr = ~gid;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        req_valid = 2'($urandom);
        req_op    = 2'($urandom);
        #1;
        check_eq("ready_in_reset", {30'd0, req_ready}, 32'd0);
        @(posedge clk);
        cyc++;
        q.delete();
        m_ptr     = 1'b0;
        m_last[0] = 32'd0;
        m_last[1] = 32'd0;
        @(negedge clk);
        check_outputs();
        rstn = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(2'b00, 2'b00, 0, 0, 0, 0);
    endtask

    initial begin
        rstn      = 1'b0;
        req_valid = 2'b00;
        req_op    = 2'b00;
        req_x1_0  = '0;
        req_x2_0  = '0;
        req_x1_1  = '0;
        req_x2_1  = '0;
        m_last[0] = 32'd0;
        m_last[1] = 32'd0;
        @(negedge clk);
        do_reset();
        do_reset();

        // Port 0 alone: 1.0 - 0.5
        cycle(2'b01, 2'b00, 8, 4, 0, 0);
        idle(4);
        // Port 1 alone: 1.0 + 1.0
        cycle(2'b10, 2'b10, 0, 0, 8, 8);
        idle(4);
        // Exact cancellation: 3-3 and 3+(-3)
        cycle(2'b01, 2'b00, 24, 24, 0, 0);
        cycle(2'b10, 2'b10, 0, 0, 24, -24);
        idle(4);

        // Both requesting every cycle right after reset
        do_reset();
        for (int i = 0; i < 8; i++) cycle(2'b11, 2'($urandom), rv(), rv(), rv(), rv());
        idle(4);

        // Port 0 burst of four
        for (int i = 0; i < 4; i++) cycle(2'b01, 2'($urandom), rv(), rv(), 0, 0);
        idle(4);

        // Reset with two operations in flight, then contention
        cycle(2'b10, 2'b00, 0, 0, rv(), rv());
        cycle(2'b01, 2'b00, rv(), rv(), 0, 0);
        cycle(2'b01, 2'b01, rv(), rv(), 0, 0);
        do_reset();
        idle(4);
        cycle(2'b11, 2'($urandom), rv(), rv(), rv(), rv());
        cycle(2'b11, 2'($urandom), rv(), rv(), rv(), rv());
        idle(4);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(2'($urandom), 2'($urandom), rv(), rv(), rv(), rv());
            if ($urandom_range(99) == 0) do_reset();
        end
        idle(LAT + 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
